// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer slice.
//   - datapath/opcode widths and register-file geometry
//   - ALU opcode constants
//   - sequencer state enum
//   - instruction field positions and a decode helper
package alu_seq_pkg;

    localparam int NUM_REGS  = 4;
    localparam int DATA_W    = 4;
    localparam int OP_W      = 3;
    localparam int INSTR_W   = 8;
    localparam int REG_IDX_W = 2;

    localparam logic [OP_W-1:0] OP_FWD  = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_AND  = 3'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_SHL2 = 3'd7;

    // Instruction layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] reserved
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs;
    } dec_t;

    // The reserved bit is deliberately dropped here.
    function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
        dec_t d;
        d.op = ins[OP_MSB:OP_LSB];
        d.rd = ins[RD_MSB:RD_LSB];
        d.rs = ins[RS_MSB:RS_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake plus the ALU issue/result bus.
//   instr_valid/instr/instr_ready : fetch -> sequencer handshake
//   alu_en/alu_opcode/alu_in_1/2  : sequencer -> ALU
//   alu_result                    : ALU -> sequencer (registered in the ALU)
// Modports: slave = the sequencer, master = the fetch/ALU environment.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic                 instr_valid;
    logic [INSTR_W-1:0]   instr;
    logic                 instr_ready;
    logic                 alu_en;
    logic [OP_W-1:0]      alu_opcode;
    logic [DATA_W-1:0]    alu_in_1;
    logic [DATA_W-1:0]    alu_in_2;
    logic [DATA_W-1:0]    alu_result;

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2
    );

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4 x 4-bit register file for the ALU sequencer.
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   ra_sel/ra_data      : combinational read port A (in_1 operand)
//   rb_sel/rb_data      : combinational read port B (in_2 operand)
//   dbg_sel/dbg_data    : combinational debug read port
//   wb_en/wb_sel/wb_data: ALU write-back port (wins on index collision)
//   ld_en/ld_sel/ld_data: direct load port
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra_sel,
    output logic [DATA_W-1:0]    ra_data,
    input  logic [REG_IDX_W-1:0] rb_sel,
    output logic [DATA_W-1:0]    rb_data,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_sel,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_sel,
    input  logic [DATA_W-1:0]    ld_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Per-entry select so a load to a different index still lands
            // in the same cycle as a write-back.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en && (wb_sel == REG_IDX_W'(i))) begin
                    regs[i] <= wb_data;
                end else if (ld_en && (ld_sel == REG_IDX_W'(i))) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    assign ra_data  = regs[ra_sel];
    assign rb_data  = regs[rb_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issuing end of the ALU interface.
// Accepts an 8-bit instruction, reads rd/rs from the register file, drives
// the ALU for one cycle, then writes the ALU's registered result back to rd.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : instruction handshake and ALU bus
//   load_valid/sel/data   : direct register-file write (any state)
//   done                  : one-cycle pulse after each write-back
//   dbg_sel/dbg_data      : combinational register read-out
//   zero                  : (ALU_SEQ_ZERO_FLAG_EN only) last result == 0
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_sequencer_if.slave       bus,
    input  logic                 load_valid,
    input  logic [REG_IDX_W-1:0] load_sel,
    input  logic [DATA_W-1:0]    load_data,
    output logic                 done,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                 zero
`endif
);

    state_t            state, state_nxt;
    dec_t              dec_p0;
    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] rd_data, rs_data;

    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_sel   (dec_p0.rd),
        .ra_data  (rd_data),
        .rb_sel   (dec_p0.rs),
        .rb_data  (rs_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .wb_en    (wb_en),
        .wb_sel   (dec_p0.rd),
        .wb_data  (bus.alu_result),
        .ld_en    (load_valid),
        .ld_sel   (load_sel),
        .ld_data  (load_data)
    );

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        wb_en           = 1'b0;
        bus.instr_ready = 1'b0;
        bus.alu_en      = 1'b0;
        bus.alu_opcode  = '0;
        bus.alu_in_1    = '0;
        bus.alu_in_2    = '0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            // Operands come straight from the register file, so a load
            // landing at the end of this cycle is not seen by the ALU.
            ISSUE: begin
                bus.alu_en     = 1'b1;
                bus.alu_opcode = dec_p0.op;
                bus.alu_in_1   = rd_data;
                bus.alu_in_2   = rs_data;
                state_nxt      = CAPTURE;
            end
            // ALU result was registered at the end of ISSUE.
            CAPTURE: begin
                wb_en     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dec_p0 <= '0;
            done   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                dec_p0 <= decode(bus.instr);
            end
            done <= wb_en;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            if (wb_en) begin
                zero <= (bus.alu_result == '0);
            end
`endif
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issuing end of the ALU interface. Accepts 8-bit instructions over a valid/ready handshake and decodes them. Reads operands from an internal 4x4-bit register file and drives the ALU's en/opcode/in_1/in_2 inputs. Captures the ALU's registered result and writes it back to the destination register. Sits between instruction fetch and the ALU in the 8-bit CPU.

Parameters:
NUM_REGS, 4, register-file depth; fixed at 4 by the 2-bit register fields.
DATA_W, 4, operand/result width; matches the ALU datapath.
OP_W, 3, opcode width; matches the ALU opcode.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present on instr
instr  in  8  [7:5] opcode, [4:3] rd (also in_1 source), [2:1] rs (in_2 source), [0] reserved, ignored
instr_ready  out  1  sequencer can accept an instruction
alu_en  out  1  ALU enable
alu_opcode  out  3  to ALU opcode
alu_in_1  out  4  to ALU in_1
alu_in_2  out  4  to ALU in_2
alu_result  in  4  ALU out (registered inside the ALU)
load_valid  in  1  direct register-file write request
load_sel  in  2  register index for load
load_data  in  4  value for load
done  out  1  one-cycle pulse after each write-back
dbg_sel  in  2  debug read select
dbg_data  out  4  reg[dbg_sel], combinational

Behaviour:
- States: IDLE, ISSUE, CAPTURE.
- Reset (async, rst_n=0): state=IDLE, all regs=0, latched instr=0, done=0. Outputs during reset: instr_ready=1, alu_en=0, alu_opcode/in_1/in_2=0.
- Reset mid-operation: in-flight instruction is dropped with no write-back.
- IDLE: instr_ready=1, alu_en=0. When instr_valid&&instr_ready at an edge: latch instr, go to ISSUE.
- ISSUE (1 cycle): instr_ready=0, alu_en=1, alu_opcode=instr[7:5], alu_in_1=reg[rd], alu_in_2=reg[rs]. Operands are read combinationally in this cycle. Next state: CAPTURE.
- CAPTURE (1 cycle): instr_ready=0, alu_en=0. At the closing edge: reg[rd]<=alu_result, done<=1. Next state: IDLE.
- Outside ISSUE, alu_opcode/in_1/in_2 are driven to 0.
- alu_result is sampled only in CAPTURE. The ALU has no reset, so its output is X until the first issue.
- Throughput: one instruction per 3 cycles. instr_ready is low in ISSUE and CAPTURE.
- Latency: accept edge E0, ISSUE cycle, write edge E2. done is high in the cycle after E2, and reg[rd] is visible on dbg_data in that same cycle.
- done is a registered pulse, high exactly one cycle per instruction.
- Load port: accepted in any state. reg[load_sel]<=load_data on the edge.
- Simultaneous CAPTURE write-back and load to the same register: write-back wins. Different registers: both are written.
- Load in the same cycle as ISSUE: the ALU sees the pre-load value.
- rd==rs is legal; both operands read the same register.
- Arithmetic wraps modulo 16; this is the ALU's behaviour, and the sequencer does no width extension.

Optional Feature:
ALU_SEQ_ZERO_FLAG_EN:
- Defined: adds output port zero (1 bit). zero is reset to 0. It updates at the CAPTURE edge to (alu_result==0) and holds between instructions. Loads do not affect it.
- Undefined: no zero port and no flag register.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants (OP_FWD=0, OP_ADD=1, OP_SUB=2, OP_NOT=3, OP_OR=4, OP_AND=5, OP_XOR=6, OP_SHL2=7);
  - the state enum (IDLE/ISSUE/CAPTURE);
  - instruction field bit positions.
- One natural sub-module: alu_seq_regfile. It has 4x4 storage, 2 combinational read ports plus a debug read port, and a write-back port and a load port with write-back priority.

Test Plan:
- Reset: assert rst_n=0 mid-ISSUE -> state IDLE, instr_ready=1, alu_en=0, all regs 0, done=0, no write-back after release.
- ADD: load r0=5, r1=3; instr=001_00_01_0 -> alu_en high 1 cycle with opcode=1, in_1=5, in_2=3; ALU model returns 8; r0=8; done pulses once, 3 cycles after accept.
- Wrap/SUB: r2=2, r3=7; instr=010_10_11_0 -> r2=4'hB; (zero flag build) zero=0; then r2=0 with SUB r2,r2 -> zero=1.
- Back-to-back: instr_valid held high with 3 instructions -> instr_ready low 2 cycles after each accept; exactly 3 done pulses, spaced 3 cycles apart.
- Collision: CAPTURE writing r1=6 while load_sel=1, load_data=9 -> r1=6. Same cycle, load to r2=9 -> r2=9.
- Operand hazard: load r0=4 during ISSUE of NOT r0 (old r0=1) -> alu_in_1=1, r0 ends 4'hE.
